pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline control tracker for the 5-stage RV32I core; consumes the decoder's packed bundles `id_ex[4:0]`, `id_m[2:0]` and `id_wb[2:0]`.
- Registers the bundles through ID/EX, EX/MEM and MEM/WB, and unpacks them into per-stage control signals.
- Detects load-use hazards (stall), resolves branches in EX (redirect and flush), and produces operand-forwarding selects for EX.
- Sits between the decoder/IF-ID register and the datapath stage registers.

Parameters:
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_ex  in  5  {alu_src_b, alu_op[3:0]}
- id_m  in  3  {branch, b_type (1=beq, 0=bne), mem_write}
- id_wb  in  3  {reg_write, mem_to_reg[1:0]}; mem_to_reg: 00 alu, 01 imm, 10 pc+4, 11 mem
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices of the ID instruction
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- ex_zero  in  1  ALU zero flag for the EX instruction
- ex_jump  in  1  EX instruction is jal/jalr (unconditional redirect)
- stall  out  1  hold PC and IF/ID
- flush  out  1  squash IF/ID (wrong path)
- ex_pc_sel  out  1  EX redirects PC
- ex_alu_src_b  out  1  EX ALU B-operand select
- ex_alu_op  out  4  EX ALU operation
- ex_fwd_a, ex_fwd_b  out  2  forward select: 00 regfile, 01 EX/MEM result, 10 MEM/WB write data
- mem_write  out  1  MEM-stage store enable
- mem_rd  out  REG_AW  MEM-stage destination register
- mem_reg_write  out  1  MEM-stage destination-write flag
- wb_reg_write  out  1  WB register-file write enable
- wb_mem_to_reg  out  2  WB result select
- wb_rd  out  REG_AW  WB destination register

Behaviour:
- Stage state:
  - ID/EX holds {valid, ex 5b, m 3b, wb 3b, rs1, rs2, rd}.
  - EX/MEM and MEM/WB hold {valid, m, wb, rd}.
  - All updates occur on the rising edge of `clk`.
- Reset (`rst` sampled high at an edge):
  - All valid bits and stored fields are cleared to 0, so every output is 0.
  - Reset mid-operation discards all in-flight instructions immediately. No state survives.
- Bubble: valid=0 with all control fields 0. An invalid stage never writes memory, writes a register or forwards.
- Load-use hazard, `ld_hz`, is true when all of the following hold:
  - ID/EX is valid;
  - ID/EX `mem_to_reg` = 11;
  - ID/EX `reg_write` = 1;
  - ID/EX `rd` != 0;
  - `id_valid` = 1;
  - `id_use_rs1` and `id_rs1` = ID/EX `rd`, or `id_use_rs2` and `id_rs2` = ID/EX `rd`.
- `stall` = `ld_hz` & ~`ex_pc_sel` (combinational).
  - While stalled, ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance normally.
  - Exactly one stall cycle per load-use pair.
- Branch/jump resolution in EX (combinational from ID/EX and inputs):
  - `ex_pc_sel` = valid & (`ex_jump` | (branch & (b_type ? `ex_zero` : ~`ex_zero`))).
  - `flush` = `ex_pc_sel`.
  - On the next edge, ID/EX loads a bubble. The upstream IF/ID register squashes on `flush`.
- Precedence: flush beats stall, because the ID instruction is wrong-path. When both conditions hold, `stall` = 0.
- Normal advance: ID/EX loads the decoder bundles and indices, with valid = `id_valid`. Fields are zeroed when `id_valid` = 0.
- Forwarding for operand A (B is identical using rs2), decided in EX:
  - 01 when EX/MEM is valid, EX/MEM `reg_write`, EX/MEM `rd` != 0, and EX/MEM `rd` = ID/EX `rs1`;
  - else 10 when the MEM/WB equivalent matches;
  - else 00.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- Output mapping:
  - Every output is a pure function of the stage registers plus `ex_zero`/`ex_jump`/ID inputs.
  - There is no additional output latency.
  - Decoder bundles reach EX 1 cycle, MEM 2 cycles and WB 3 cycles after being presented with `id_valid`.

Test Plan:
- Reset: hold `rst` 2 cycles with random inputs → every output = 0, including `ex_fwd_a`/`ex_fwd_b` = 00.
- Straight-line: `addi x1` then `add x2,x1,x1` back-to-back, both id_valid → in the `add` EX cycle, `ex_fwd_a` = `ex_fwd_b` = 01. One cycle later with an independent instruction reading x1 in EX → 10. `wb_rd` = 1, `wb_reg_write` = 1 three cycles after the `addi` was presented.
- Load-use: `lw x5` followed by `add x6,x5,x0` → `stall` = 1 for exactly one cycle, then the `add` enters EX with `ex_fwd_a` = 10. With x0 as the `lw` destination → no stall.
- Branch: `bne` with `ex_zero` = 0 → `ex_pc_sel` = `flush` = 1 for one cycle, and the next EX cycle shows a bubble (`ex_alu_op` = 0, no fwd). Same with `ex_zero` = 1 → no redirect. For `beq`, the inverse holds.
- Simultaneous: load in ID/EX, dependent instruction in ID, and `ex_jump` = 1 → `flush` = 1, `stall` = 0, and ID/EX becomes a bubble.
- Reset mid-flight: assert `rst` while a store is in EX/MEM → `mem_write` = 0 on the following cycle, and the pipeline refills only from new id_valid input.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline control tracker: stage control registers, load-use stall, EX branch resolve, forwarding
module pipe_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_ex,
  input  logic [2:0]        id_m,
  input  logic [2:0]        id_wb,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_zero,
  input  logic              ex_jump,
  output logic              stall,
  output logic              flush,
  output logic              ex_pc_sel,
  output logic              ex_alu_src_b,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              wb_reg_write,
  output logic [1:0]        wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd
);

  logic              idex_valid;
  logic [4:0]        idex_ex;
  logic [2:0]        idex_m;
  logic [2:0]        idex_wb;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic [REG_AW-1:0] idex_rd;

  // Only the store enable of the memory bundle is needed past EX.
  logic              exmem_valid;
  logic              exmem_mw;
  logic [2:0]        exmem_wb;
  logic [REG_AW-1:0] exmem_rd;

  logic              memwb_valid;
  logic [2:0]        memwb_wb;
  logic [REG_AW-1:0] memwb_rd;

  logic ld_hz;
  logic exmem_fwd;
  logic memwb_fwd;

  assign ld_hz = idex_valid && (idex_wb == 3'b111) && (idex_rd != '0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == idex_rd)) || (id_use_rs2 && (id_rs2 == idex_rd)));

  assign ex_pc_sel = idex_valid & (ex_jump | (idex_m[2] & (idex_m[1] ? ex_zero : ~ex_zero)));
  assign flush     = ex_pc_sel;
  // The ID instruction is wrong-path on a redirect, so stalling for it is pointless.
  assign stall     = ld_hz & ~ex_pc_sel;

  assign exmem_fwd = exmem_valid & exmem_wb[2] & (exmem_rd != '0);
  assign memwb_fwd = memwb_valid & memwb_wb[2] & (memwb_rd != '0);

  always_comb begin
    ex_fwd_a = 2'b00;
    ex_fwd_b = 2'b00;
    if (exmem_fwd && (exmem_rd == idex_rs1))      ex_fwd_a = 2'b01;
    else if (memwb_fwd && (memwb_rd == idex_rs1)) ex_fwd_a = 2'b10;
    if (exmem_fwd && (exmem_rd == idex_rs2))      ex_fwd_b = 2'b01;
    else if (memwb_fwd && (memwb_rd == idex_rs2)) ex_fwd_b = 2'b10;
  end

  assign ex_alu_src_b  = idex_ex[4];
  assign ex_alu_op     = idex_ex[3:0];
  assign mem_write     = exmem_valid & exmem_mw;
  assign mem_rd        = exmem_rd;
  assign mem_reg_write = exmem_valid & exmem_wb[2];
  assign wb_reg_write  = memwb_valid & memwb_wb[2];
  assign wb_mem_to_reg = memwb_wb[1:0];
  assign wb_rd         = memwb_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid  <= 1'b0;
      idex_ex     <= '0;
      idex_m      <= '0;
      idex_wb     <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_rd     <= '0;
      exmem_valid <= 1'b0;
      exmem_mw    <= 1'b0;
      exmem_wb    <= '0;
      exmem_rd    <= '0;
      memwb_valid <= 1'b0;
      memwb_wb    <= '0;
      memwb_rd    <= '0;
    end else begin
      if (!id_valid || flush || stall) begin
        idex_valid <= 1'b0;
        idex_ex    <= '0;
        idex_m     <= '0;
        idex_wb    <= '0;
        idex_rs1   <= '0;
        idex_rs2   <= '0;
        idex_rd    <= '0;
      end else begin
        idex_valid <= 1'b1;
        idex_ex    <= id_ex;
        idex_m     <= id_m;
        idex_wb    <= id_wb;
        idex_rs1   <= id_rs1;
        idex_rs2   <= id_rs2;
        idex_rd    <= id_rd;
      end
      exmem_valid <= idex_valid;
      exmem_mw    <= idex_m[0];
      exmem_wb    <= idex_wb;
      exmem_rd    <= idex_rd;
      memwb_valid <= exmem_valid;
      memwb_wb    <= exmem_wb;
      memwb_rd    <= exmem_rd;
    end
  end

endmodule
